// File: rtl/result_display_mux.sv
// result_display_mux: keeps the last NUM_DIGITS results and scans them onto a
// common-anode 7-segment display with dead time. Optional DISPLAY_HEX_EN decodes codes 10..15.
module result_display_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int RESULT_W = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_TIMEOUT = 0,
  localparam int CW = $clog2(NUM_DIGITS + 1),
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1,
  localparam int PW = $clog2(REFRESH_DIV),
  localparam int TW = BLANK_TIMEOUT > 0 ? $clog2(BLANK_TIMEOUT + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  result_valid,
  input  logic [RESULT_W-1:0]   result_in,
  input  logic                  clear,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic [CW-1:0]         history_count
);
  logic [RESULT_W-1:0] val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] vld;
  logic [PW-1:0] pcnt;
  logic [IW-1:0] scan_idx;
  logic [TW-1:0] idle_cnt;
  logic tmo, clr, last;
  logic [6:0] seg_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic dp_d;

  function automatic logic [6:0] decode(input logic [RESULT_W-1:0] v);
    logic [6:0] s;
    case (v[3:0])
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
`ifdef DISPLAY_HEX_EN
      4'd10: s = 7'b0001000;
      4'd11: s = 7'b0000011;
      4'd12: s = 7'b1000110;
      4'd13: s = 7'b0100001;
      4'd14: s = 7'b0000110;
      default: s = 7'b0001110;
`else
      default: s = 7'h7F;
`endif
    endcase
    return (v >> 4) != '0 ? 7'h7F : s;
  endfunction

  // Timeout fires while the idle counter sits saturated, acting exactly like clear.
  assign tmo = BLANK_TIMEOUT > 0 && idle_cnt == TW'(BLANK_TIMEOUT);
  assign clr = clear | tmo;
  assign last = pcnt == PW'(REFRESH_DIV - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) idle_cnt <= '0;
    else idle_cnt <= (BLANK_TIMEOUT == 0 || result_valid || clear) ? '0 : (tmo ? idle_cnt : idle_cnt + 1'b1);
  end

  always_ff @(posedge clk) begin
    if (result_valid) val[0] <= result_in;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (result_valid) val[i] <= val[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      history_count <= '0;
    end else begin
      for (int i = NUM_DIGITS - 1; i > 0; i--)
        vld[i] <= clr ? 1'b0 : (result_valid ? vld[i-1] : vld[i]);
      vld[0] <= result_valid | (~clr & vld[0]);
      history_count <= result_valid ? (clr ? CW'(1) : (history_count == CW'(NUM_DIGITS) ? history_count : history_count + 1'b1))
                                    : (clr ? '0 : history_count);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
      scan_idx <= '0;
    end else begin
      pcnt <= last ? '0 : pcnt + 1'b1;
      scan_idx <= last ? (scan_idx == IW'(NUM_DIGITS - 1) ? '0 : scan_idx + 1'b1) : scan_idx;
    end
  end

  always_comb begin
    seg_d = (pcnt == '0 || !vld[scan_idx]) ? 7'h7F : decode(val[scan_idx]);
    an_d = pcnt == '0 ? '1 : ~(NUM_DIGITS'(1) << scan_idx);
    dp_d = !(pcnt != '0 && scan_idx == '0 && vld[0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= 7'h7F;
      an <= '1;
      dp <= 1'b1;
    end else begin
      seg <= seg_d;
      an <= an_d;
      dp <= dp_d;
    end
  end
endmodule

// File: tb/tb_result_display_mux.sv
// tb_result_display_mux: random and directed stimulus against a queue-based display model.
module tb_result_display_mux;
  localparam int N = 4, RD = 8, TO = 50;
  logic clk = 0, rst_n = 0, rv = 0, clr = 0;
  logic [4:0] rin = '0;
  logic [6:0] seg;
  logic [N-1:0] an;
  logic dp;
  logic [2:0] history_count;
  int checks = 0, errors = 0;
  int q[$];
  int e = 0, idle = 0;
  logic [6:0] seg_tab [16];

  result_display_mux #(.NUM_DIGITS(N), .RESULT_W(5), .REFRESH_DIV(RD), .BLANK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .result_valid(rv), .result_in(rin), .clear(clr),
    .seg(seg), .an(an), .dp(dp), .history_count(history_count));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  function automatic logic [6:0] dec(input int v);
    return v > 15 ? 7'h7F : seg_tab[v];
  endfunction

  task automatic step();
    logic [6:0] es;
    logic [N-1:0] ea;
    logic ed;
    int p, s;
    if (!rst_n) begin
      es = 7'h7F; ea = '1; ed = 1;
    end else begin
      p = e % RD;
      s = (e / RD) % N;
      ea = p == 0 ? '1 : ~(N'(1) << s);
      es = (p != 0 && s < q.size()) ? dec(q[s]) : 7'h7F;
      ed = !(p != 0 && s == 0 && q.size() > 0);
    end
    if (!rst_n) begin
      q.delete(); e = 0; idle = 0;
    end else begin
      e++;
      if (clr || idle == TO) q.delete();
      if (rv) begin
        q.push_front(int'(rin));
        if (q.size() > N) void'(q.pop_back());
      end
      idle = (rv || clr) ? 0 : (idle < TO ? idle + 1 : TO);
    end
    @(posedge clk);
    #1;
    check("seg", seg, es);
    check("an", an, ea);
    check("dp", dp, ed);
    check("count", history_count, q.size());
  endtask

  task automatic cyc(input bit v, input int val, input bit c);
    rv = v; rin = 5'(val); clr = c;
    step();
    rv = 0; clr = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`ifdef DISPLAY_HEX_EN
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011; seg_tab[12] = 7'b1000110;
    seg_tab[13] = 7'b0100001; seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
`endif
    run(3);
    rst_n = 1;
    run(5);
    foreach (seg_tab[i]) if (i < 10) ;
    cyc(1, 3, 0); cyc(1, 7, 0); cyc(1, 1, 0); cyc(1, 9, 0); cyc(1, 5, 0);
    check("saturate", history_count, 4);
    run(40);
    cyc(1, 2, 1);
    check("clr_and_valid", history_count, 1);
    run(40);
    cyc(1, 12, 0);
    run(40);
    cyc(1, 19, 0);
    run(40);
    cyc(1, 4, 1);
    run(45);
    check("before_timeout", history_count, 1);
    run(25);
    check("timeout", history_count, 0);
    cyc(1, 4, 0);
    run(48);
    cyc(1, 6, 0);
    run(30);
    check("restart", history_count, 2);
    run(13);
    rst_n = 0;
    step();
    rst_n = 1;
    run(20);
    for (int i = 0; i < 1500; i++) begin
      rst_n = $urandom_range(0, 299) != 0;
      cyc($urandom_range(0, 9) < 3, int'($urandom_range(0, 31)), $urandom_range(0, 32) == 0);
    end
    rst_n = 1;
    run(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
